// File: rtl/avg5_prefilter.sv
// avg5_prefilter: per-channel 5-tap moving-average anti-alias filter ahead of a decimate-by-5 stage
module avg5_prefilter #(
  parameter int DATA_W   = 24,
  parameter int CH_W     = 2,
  parameter int TAPS     = 5,
  parameter int SCALE    = 13107,
  parameter int SCALE_SH = 16
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [CH_W-1:0]   s_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [CH_W-1:0]   m_axis_tuser
);
  localparam int NUM_CH = 2**CH_W;
  localparam int PW     = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + PW;
  localparam int PROD_W = ACC_W + 16;

  logic signed [ACC_W-1:0] hist [NUM_CH][TAPS];
  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic [PW-1:0]           wptr [NUM_CH];
  logic                    en, fire, s1_valid;
  logic [CH_W-1:0]         s1_ch;
  logic signed [ACC_W-1:0] s1_acc, x, old, acc_new;
  logic signed [PROD_W-1:0] prod, rnd;

  assign en            = !m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = en;
  assign fire          = en & s_axis_tvalid;
  assign x             = {{(ACC_W-DATA_W){s_axis_tdata[DATA_W-1]}}, s_axis_tdata};
  assign old           = hist[s_axis_tuser][wptr[s_axis_tuser]];
  // running sum: add the newest sample, drop the one falling out of the window
  assign acc_new       = acc[s_axis_tuser] + x - old;
  assign prod          = PROD_W'(s1_acc) * PROD_W'(SCALE);
  assign rnd           = prod + PROD_W'(2**(SCALE_SH-1));

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]  <= '0;
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end
      s1_valid      <= 1'b0;
      s1_acc        <= '0;
      s1_ch         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
    end else if (en) begin
      s1_valid <= fire;
      if (fire) begin
        acc[s_axis_tuser]                     <= acc_new;
        hist[s_axis_tuser][wptr[s_axis_tuser]] <= x;
        wptr[s_axis_tuser] <= (wptr[s_axis_tuser] == PW'(TAPS-1)) ? '0 : wptr[s_axis_tuser] + 1'b1;
        s1_acc <= acc_new;
        s1_ch  <= s_axis_tuser;
      end
      m_axis_tvalid <= s1_valid;
      m_axis_tuser  <= s1_ch;
      m_axis_tdata  <= DATA_W'(rnd >>> SCALE_SH);
    end
  end
endmodule

// File: tb/tb_avg5_prefilter.sv
// tb_avg5_prefilter: directed vector table plus hand-written latency, backpressure and reset sequences
module tb_avg5_prefilter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn  = 1'b0;
  logic [23:0] s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [1:0]  s_tuser  = '0;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  m_tuser;

  avg5_prefilter dut (
    .s_axis_aclk(clk), .s_axis_aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tuser(m_tuser)
  );

  typedef struct {
    logic [1:0] ch;
    int         d;
    int         e;
  } vec_t;

  vec_t vecs[$];
  vec_t got[$];
  int   total = 0, bad = 0;
  int   snap_d, snap_u;

  // output handshakes are recorded just after the falling edge, ahead of the rising edge that completes them
  always @(negedge clk) begin
    #1;
    if (m_tvalid && m_tready && aresetn) got.push_back('{m_tuser, 0, int'($signed(m_tdata))});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] ch, input int d);
    int n;
    @(negedge clk);
    s_tdata  = d[23:0];
    s_tuser  = ch;
    s_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("s_tready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    aresetn  = 1'b1;
  endtask

  task automatic add(input logic [1:0] ch, input int d, input int e);
    vecs.push_back('{ch, d, e});
  endtask

  task automatic run_vecs(input string nm);
    got.delete();
    foreach (vecs[i]) send(vecs[i].ch, vecs[i].d);
    idle(4);
    chk({nm, "_count"}, got.size(), vecs.size());
    foreach (vecs[i])
      if (i < got.size()) begin
        chk($sformatf("%s_data%0d", nm, i), got[i].e, vecs[i].e);
        chk($sformatf("%s_tuser%0d", nm, i), int'(got[i].ch), int'(vecs[i].ch));
      end
    vecs.delete();
  endtask

  task automatic stall();
    repeat (6) @(negedge clk);
    m_tready = 1'b0;
    #1;
    snap_d = int'(m_tdata);
    snap_u = int'(m_tuser);
    chk("bp_valid_at_stall", int'(m_tvalid), 1);
    repeat (6) begin
      #1;
      chk("bp_s_tready_low", int'(s_tready), 0);
      chk("bp_tdata_hold", int'(m_tdata), snap_d);
      chk("bp_tuser_hold", int'(m_tuser), snap_u);
      @(negedge clk);
    end
    m_tready = 1'b1;
  endtask

  initial begin
    int pos_ramp [7] = '{1677696, 3355392, 5033087, 6710783, 8388479, 8388479, 8388479};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_m_tdata", int'(m_tdata), 0);
    chk("rst_m_tuser", int'(m_tuser), 0);
    chk("rst_s_tready", int'(s_tready), 1);
    @(negedge clk);
    aresetn = 1'b1;

    send(2'd0, 1000);
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("lat_valid_cycle1", int'(m_tvalid), 0);
    @(negedge clk);
    #1;
    chk("lat_valid_cycle2", int'(m_tvalid), 1);
    chk("lat_data", int'($signed(m_tdata)), 200);
    chk("lat_tuser", int'(m_tuser), 0);
    do_reset();

    for (int k = 1; k <= 7; k++) add(2'd0, 1000, 200 * (k < 5 ? k : 5));
    run_vecs("ch0_ramp");
    for (int k = 1; k <= 7; k++) add(2'd1, -1000, -200 * (k < 5 ? k : 5));
    run_vecs("ch1_ramp");

    do_reset();
    for (int r = 0; r < 6; r++) begin
      add(2'd0, 5000, 1000 * (r < 5 ? r + 1 : 5));
      add(2'd1, -5000, -1000 * (r < 5 ? r + 1 : 5));
      add(2'd2, 0, 0);
      add(2'd3, r == 0 ? 8388607 : 0, r < 5 ? 1677696 : 0);
    end
    run_vecs("rr");

    do_reset();
    for (int k = 0; k < 7; k++) add(2'd2, 8388607, pos_ramp[k]);
    run_vecs("fs_pos");
    do_reset();
    for (int k = 1; k <= 7; k++) add(2'd2, -8388608, -1677696 * (k < 5 ? k : 5));
    run_vecs("fs_neg");

    do_reset();
    for (int k = 1; k <= 8; k++) begin
      add(2'd0, 1000, 200 * (k < 5 ? k : 5));
      add(2'd1, -1000, -200 * (k < 5 ? k : 5));
    end
    fork
      run_vecs("bp");
      stall();
    join

    do_reset();
    repeat (6) send(2'd0, 1000);
    @(negedge clk);
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    @(negedge clk);
    aresetn  = 1'b1;
    #1;
    chk("midrst_m_tvalid", int'(m_tvalid), 0);
    chk("midrst_m_tdata", int'(m_tdata), 0);
    for (int k = 1; k <= 3; k++) add(2'd0, 1000, 200 * k);
    run_vecs("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
